uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Buffered, parametrised UART transmitter and the successor to the single-byte TX wrapper.
- Bytes are written into an internal FIFO.
- A framing FSM serialises them back-to-back with configurable data width, parity and stop bits.
- Sits between the sensor/MLP result logic and the board UART pin, so producers need not poll tx_busy per byte.

Parameters:
- BPS_NUM, 16'd234, clk cycles per bit (27 MHz / 115200); legal range ≥ 2.
- DATA_BITS, 8, payload bits per frame; legal range 5..8.
- PARITY_MODE, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_data  in  DATA_BITS  byte to enqueue
- wr_en  in  1  enqueue strobe; accepted only when !full
- full  out  1  FIFO full
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently held (not including the frame in flight)
- overflow  out  1  sticky flag: wr_en seen while full
- clr_overflow  in  1  clears overflow
- uart_tx  out  1  serial line, idle high
- tx_busy  out  1  high while a frame is in flight or the FIFO is non-empty

Behaviour:
- Reset values (rst sampled high at a clk edge): uart_tx=1, tx_busy=0, full=0, fifo_count=0, overflow=0, FSM=IDLE, baud counter=0.
  - FIFO contents are discarded.
  - Reset mid-frame truncates the frame; uart_tx returns high on the next cycle.
- FIFO:
  - Write when wr_en && !full; the data is visible to the FSM on the next cycle.
  - wr_en while full: data dropped, overflow set on the next cycle.
  - clr_overflow clears overflow. If clr_overflow and a new overflowing write occur in the same cycle, set wins.
  - A pop and a write in the same cycle are both honoured; fifo_count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. full is (fifo_count==FIFO_DEPTH).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, go to START, clear the baud counter.
  - START: uart_tx=0 for BPS_NUM cycles.
  - DATA: LSB first, DATA_BITS bits, each held for BPS_NUM cycles.
  - PARITY: entered only if PARITY_MODE!=0.
    - Even mode: bit = XOR of the payload.
    - Odd mode: bit = ~XOR of the payload.
    - Held for BPS_NUM cycles.
  - STOP: uart_tx=1 for STOP_BITS*BPS_NUM cycles.
  - At the end of STOP: if the FIFO is non-empty, go directly to START with the next popped word (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..BPS_NUM-1. The bit index advances when the counter equals BPS_NUM-1.
- Timing:
  - Latency from the wr_en edge (into an empty FIFO with FSM IDLE) to uart_tx falling is 2 clk cycles: write, then pop, then uart_tx registered low.
  - Frame length = BPS_NUM*(1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS) cycles.
- uart_tx is driven from a register (glitch-free).
- tx_busy = (state!=IDLE) || (fifo_count!=0), registered. It drops in the cycle the FSM returns to IDLE with an empty FIFO.
- Illegal parameter values are caught by elaboration-time checks (generate-time error).

Decomposition:
- Package uart_pkg holds:
  - PARITY_NONE/ODD/EVEN constants;
  - the FSM state encoding typedef;
  - a function computing the frame bit count from the parameters.
- One natural sub-module: uart_sync_fifo (parameters WIDTH, DEPTH; ports clk, rst, wr_en, wr_data, rd_en, rd_data, full, empty, count), reusable by a future RX path.
- The framing FSM and baud counter stay in uart_tx_fifo.

Test Plan:
- BPS_NUM=4, 8N1, write 8'hA5 into an empty FIFO -> uart_tx falls 2 cycles after wr_en; bits 1,0,1,0,0,1,0,1 at 4-cycle spacing; stop bit high; total frame 40 cycles; tx_busy low afterwards.
- BPS_NUM=4, DATA_BITS=7, even parity, 2 stop bits, send 7'h13 -> parity bit 1; 2 stop bits = 8 high cycles; frame 44 cycles.
- FIFO_DEPTH=4, write 0x01..0x06 in consecutive cycles while the first frame starts -> 5 accepted (1 popped + 4 held); sixth dropped and overflow=1; line shows 0x01..0x05 back-to-back with no idle gap between stop and start.
- Write while full, with clr_overflow asserted in the same cycle -> overflow remains 1; clr_overflow alone on a later cycle -> overflow 0.
- Write 8'hFF, then assert rst during the 3rd data bit -> next cycle uart_tx=1, tx_busy=0, fifo_count=0; a subsequent write of 8'h00 transmits cleanly.
- Simultaneous pop and write with fifo_count=2 -> fifo_count stays 2; data order is preserved on the line.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and frame sizing for the UART transmit path.
package uart_pkg;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_ODD  = 1;
   localparam int unsigned PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   // Bits on the line for one frame: start + payload + optional parity + stop bits.
   function automatic int unsigned frame_bits(input int unsigned data_bits,
                                              input int unsigned parity_mode,
                                              input int unsigned stop_bits);
      return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a first-word-fall-through head, so a consumer can pop
// and use rd_data in the same cycle.
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_wr, do_rd;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      do_wr    = wr_en && !full;
      do_rd    = rd_en && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_wr && !do_rd) count_d = count_q + (AW+1)'(1);
      if (!do_wr && do_rd) count_d = count_q - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes queue in a FIFO and a framing FSM sends them
// back-to-back with configurable width, parity and stop bits.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter logic [15:0] BPS_NUM     = 16'd234,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY_MODE = 0,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned FIFO_DEPTH  = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_BITS-1:0]           wr_data,
   input  logic                           wr_en,
   output logic                           full,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
   output logic                           overflow,
   input  logic                           clr_overflow,
   output logic                           uart_tx,
   output logic                           tx_busy
);

   generate
      if (BPS_NUM < 16'd2) begin : g_bad_bps
         $error("uart_tx_fifo: BPS_NUM must be at least 2");
      end
      if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
         $error("uart_tx_fifo: DATA_BITS must be 5..8");
      end
      if (PARITY_MODE > PARITY_EVEN) begin : g_bad_parity
         $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
      end
      if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
         $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
      end
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
      end
   endgenerate

   localparam int unsigned       FRAME_BITS = frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS);
   localparam int unsigned       IDX_W      = $clog2(FRAME_BITS);
   localparam logic [IDX_W-1:0]  LAST_DATA  = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0]  LAST_STOP  = IDX_W'(STOP_BITS - 1);
   localparam bit                HAS_PARITY = (PARITY_MODE != PARITY_NONE);
   localparam logic [15:0]       BAUD_LAST  = BPS_NUM - 16'd1;

   tx_state_e              state_q, state_d;
   logic [15:0]            baud_q, baud_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_q, par_d;
   logic                   uart_tx_q, uart_tx_d;
   logic                   busy_q, busy_d;
   logic                   ovf_q, ovf_d;

   logic                   load;
   logic                   baud_done;
   logic                   fifo_empty;
   logic                   fifo_full;
   logic [DATA_BITS-1:0]   head_data;
   logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

   function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
      return (PARITY_MODE == PARITY_ODD) ? ~(^d) : (^d);
   endfunction

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (load),
      .rd_data (head_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_cnt)
   );

   assign baud_done = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      load    = 1'b0;

      case (state_q)
         ST_IDLE: load = !fifo_empty;
         ST_START: begin
            if (baud_done) begin
               state_d = ST_DATA;
               baud_d  = '0;
               idx_d   = '0;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         ST_DATA: begin
            if (baud_done) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (idx_q == LAST_DATA) begin
                  idx_d   = '0;
                  state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         ST_PARITY: begin
            if (baud_done) begin
               baud_d  = '0;
               idx_d   = '0;
               state_d = ST_STOP;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         ST_STOP: begin
            if (baud_done) begin
               baud_d = '0;
               // Chain straight into the next start bit when more data is waiting.
               if (idx_q == LAST_STOP) begin
                  if (fifo_empty) state_d = ST_IDLE;
                  else            load    = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         shift_d = head_data;
         par_d   = parity_of(head_data);
         state_d = ST_START;
         baud_d  = '0;
         idx_d   = '0;
      end

      case (state_q)
         ST_START:  uart_tx_d = 1'b0;
         ST_DATA:   uart_tx_d = shift_q[0];
         ST_PARITY: uart_tx_d = par_q;
         default:   uart_tx_d = 1'b1;
      endcase

      busy_d = (state_q != ST_IDLE) || (fifo_cnt != '0);

      // A fresh overflowing write takes priority over the clear.
      ovf_d = ovf_q;
      if (clr_overflow)         ovf_d = 1'b0;
      if (wr_en && fifo_full)   ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         baud_q    <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         uart_tx_q <= 1'b1;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         uart_tx_q <= uart_tx_d;
         busy_q    <= busy_d;
         ovf_q     <= ovf_d;
      end
   end

   assign full       = fifo_full;
   assign fifo_count = fifo_cnt;
   assign overflow   = ovf_q;
   assign uart_tx    = uart_tx_q;
   assign tx_busy    = busy_q;

endmodule
